sd_block_tx: RTL

- SPI-responder MISO transmitter for SD-style single-block reads.
- On request, serialises one data block MSB-first: start token, BLOCK_LEN payload bytes pulled over a valid/ready byte interface, then the CRC16-CCITT of the payload.
- Counterpart to the MOSI-side CRC/command path.
- All logic advances on the falling edge of spi_clk, so MISO is stable for the host's rising-edge sample (SPI mode 0).

---
 rtl/sd_block_tx_if.sv | 19 +
 rtl/sd_block_tx.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/sd_block_tx_if.sv
// Byte stream feeding the SD block transmitter.
// Ports: byte_in/byte_valid from the producer, byte_ready back to it.
interface sd_block_tx_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready
    );
endinterface

// File: rtl/sd_block_tx.sv
// SPI-responder MISO transmitter for one SD-style data block.
// Ports: spi_clk/reset/en/start control, bus byte stream (slave),
//        miso serial out, busy/done/underrun status.
module sd_block_tx #(
    parameter int         BLOCK_LEN   = 512,
    parameter logic [7:0] START_TOKEN = 8'hFE
) (
    input  logic         spi_clk,
    input  logic         reset,
    input  logic         en,
    input  logic         start,
    sd_block_tx_if.slave bus,
    output logic         miso,
    output logic         busy,
    output logic         done,
    output logic         underrun
);
    localparam int CW = $clog2(BLOCK_LEN + 1);
    localparam logic [CW-1:0] LEN = CW'(BLOCK_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_TOKEN, S_DATA, S_CRC, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    byte_q, byte_d;
    logic [3:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   crc_q, crc_d;
    logic          miso_q, miso_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          urun_q, urun_d;

    logic          need_byte;
    logic [7:0]    next_byte;
    logic [3:0]    idx_m1;

    function automatic logic [15:0] crc_step(
        input logic [15:0] c,
        input logic        b
    );
        logic fb;
        fb = b ^ c[15];
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // idx_q is the index of the bit currently on miso, so a new byte
    // is due once bit 0 of the token or a payload byte is out.
    assign need_byte = (state_q == S_TOKEN || state_q == S_DATA)
                       && idx_q == 4'd0 && cnt_q < LEN;
    assign bus.byte_ready = en && !reset && need_byte;
    assign next_byte = bus.byte_valid ? bus.byte_in : 8'hFF;
    assign idx_m1 = idx_q - 4'd1;

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        miso_d  = miso_q;
        busy_d  = busy_q;
        done_d  = done_q;
        urun_d  = urun_q;
        if (en) begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_TOKEN;
                        byte_d  = START_TOKEN;
                        idx_d   = 4'd7;
                        cnt_d   = '0;
                        crc_d   = 16'h0000;
                        miso_d  = START_TOKEN[7];
                        busy_d  = 1'b1;
                        urun_d  = 1'b0;
                    end
                end
                S_TOKEN, S_DATA: begin
                    if (need_byte) begin
                        state_d = S_DATA;
                        byte_d  = next_byte;
                        idx_d   = 4'd7;
                        cnt_d   = cnt_q + CW'(1);
                        miso_d  = next_byte[7];
                        crc_d   = crc_step(crc_q, next_byte[7]);
                        if (!bus.byte_valid) begin
                            urun_d = 1'b1;
                        end
                    end else if (idx_q != 4'd0) begin
                        idx_d  = idx_m1;
                        miso_d = byte_q[idx_m1[2:0]];
                        // the token itself stays out of the CRC
                        if (state_q == S_DATA) begin
                            crc_d = crc_step(crc_q, byte_q[idx_m1[2:0]]);
                        end
                    end else begin
                        state_d = S_CRC;
                        idx_d   = 4'd15;
                        miso_d  = crc_q[15];
                    end
                end
                S_CRC: begin
                    if (idx_q != 4'd0) begin
                        idx_d  = idx_m1;
                        miso_d = crc_q[idx_m1];
                    end else begin
                        state_d = S_DONE;
                        miso_d  = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(negedge spi_clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            byte_q  <= 8'h00;
            idx_q   <= 4'd0;
            cnt_q   <= '0;
            crc_q   <= 16'h0000;
            miso_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            urun_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            miso_q  <= miso_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            urun_q  <= urun_d;
        end
    end

    assign miso     = miso_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign underrun = urun_q;
endmodule
